// File: rtl/number_display_if.sv
// Bus between the calculator core and the seven-segment display block:
// the value/request from the core plus the status and display drive back.
interface number_display_if;
  logic [31:0] num;
  logic        start;
  logic        hex_mode;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;

  modport master (
    output num, start, hex_mode,
    input  busy, done, bcd, overflow, AN, SEGMENT
  );

  modport slave (
    input  num, start, hex_mode,
    output busy, done, bcd, overflow, AN, SEGMENT
  );
endinterface

// File: rtl/number_display.sv
// Converts a 32-bit value to decimal (iterative double-dabble) or hex and
// drives an 8-digit multiplexed seven-segment display with blanking.
module number_display #(
  parameter logic [15:0] SCAN_DIV   = 16'd50000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  number_display_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned SRC_W  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned SH_W   = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               hex_pend_q, hex_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               disp_hex_q, disp_hex_d;
  logic [ACC_W+SRC_W-1:0] shifted;

  logic [15:0]        presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;
  logic [SH_W-1:0]    sh;
  logic [3:0]         nib;
  logic [31:0]        upper;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble before each shift
  always_comb begin : dabble_adjust
    adj = acc_q;
    for (int i = 0; i < ACC_W / 4; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    shifted = {adj, shift_q} << 1;
  end

  // Conversion FSM next-state and result logic
  always_comb begin : fsm_next
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    hex_pend_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    disp_hex_d = disp_hex_q;

    // Hex pass-through completes one cycle after its start
    if (hex_pend_q) begin
      bcd_d      = shift_q;
      ovf_d      = 1'b0;
      done_d     = 1'b1;
      disp_hex_d = mode_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.num;
          mode_d  = bus.hex_mode;
          if (bus.hex_mode) begin
            hex_pend_d = 1'b1;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(SRC_W)) begin
          state_d = FINISH;
        end else begin
          acc_d   = shifted[ACC_W+SRC_W-1 -: ACC_W];
          shift_d = shifted[SRC_W-1:0];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        bcd_d      = acc_q[31:0];
        ovf_d      = |acc_q[ACC_W-1:32];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        disp_hex_d = mode_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_regs
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      hex_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      disp_hex_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      hex_pend_q <= hex_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      disp_hex_q <= disp_hex_d;
    end
  end

  // Digit scan; segment pattern is computed for the digit selected after this edge
  always_comb begin : scan_next
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == SCAN_DIV - 16'd1) begin
      presc_d = '0;
      idx_d   = idx_q + IDX_W'(1);
    end
    sh    = {idx_d, 2'b00};
    nib   = bcd_q[sh +: 4];
    upper = bcd_q >> sh;
    if (!disp_hex_q && ovf_q) begin
      seg_d = (idx_d == '0) ? 8'h86 : 8'hFF;
    end else if (!disp_hex_q && (idx_d != '0) && (upper == '0)) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = glyph(nib);
    end
    an_d = ~(8'b1 << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin : scan_regs
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFE;
      seg_q   <= 8'hC0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.AN       = an_q;
  assign bus.SEGMENT  = seg_q;

endmodule

// File: tb/tb_number_display.sv
// Self-checking bench for number_display: vector table, randomized traffic
// against an arithmetic model, and scan/reset/restart corner sequences.
module tb_number_display;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  number_display_if bus ();

  number_display #(.SCAN_DIV(16'd4), .NUM_DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic        hex;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decimal digits by repeated division; hex is identity
  task automatic model_conv(input logic [31:0] n, input logic h,
                            output logic [31:0] b, output logic o);
    logic [39:0] r;
    logic [31:0] v;
    r = '0;
    v = n;
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    if (h) begin
      b = n;
      o = 1'b0;
    end else begin
      b = r[31:0];
      o = (n > 32'd99999999);
    end
  endtask

  function automatic logic [7:0] model_glyph(input logic [31:0] b, input logic o,
                                             input logic h, input int d);
    logic [7:0] tbl [16];
    logic [31:0] up;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    up = b >> (4 * d);
    if (!h && o) return (d == 0) ? 8'h86 : 8'hFF;
    if (!h && d != 0 && up == 32'd0) return 8'hFF;
    return tbl[4'(up & 32'hF)];
  endfunction

  // Issue one start; caller is positioned just after a rising edge
  task automatic run_conv(input logic [31:0] n, input logic h,
                          output logic [31:0] b, output logic o,
                          output int lat, output logic bz);
    bus.num      = n;
    bus.hex_mode = h;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    bz  = bus.busy;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) bz = 1'b1;
      if (bus.done) break;
    end
    b = bus.bcd;
    o = bus.overflow;
  endtask

  task automatic check_display(input logic [31:0] b, input logic o, input logic h,
                               input string tag);
    logic [7:0] exp_an;
    int w;
    @(posedge clk);
    #1;
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'b1 << d);
      w = 0;
      while (bus.AN !== exp_an && w < 64) begin
        @(posedge clk);
        #1;
        w++;
      end
      check($sformatf("%s_an%0d", tag, d), bus.AN, exp_an);
      check($sformatf("%s_seg%0d", tag, d), bus.SEGMENT, model_glyph(b, o, h, d));
    end
  endtask

  initial begin
    logic [31:0] b, eb;
    logic        o, eo, bz, h;
    logic [31:0] n;
    int          lat, dones;
    string       tag;

    n_checks = 0;
    n_fail   = 0;
    bus.num      = '0;
    bus.start    = 1'b0;
    bus.hex_mode = 1'b0;
    rst = 1'b0;

    vecs[0] = '{32'd12345678,  1'b0, 32'h12345678, 1'b0, 34};
    vecs[1] = '{32'd0,         1'b0, 32'h00000000, 1'b0, 34};
    vecs[2] = '{32'd100000000, 1'b0, 32'h00000000, 1'b1, 34};
    vecs[3] = '{32'd99999999,  1'b0, 32'h99999999, 1'b0, 34};
    vecs[4] = '{32'hDEADBEEF,  1'b1, 32'hDEADBEEF, 1'b0, 1};
    vecs[5] = '{32'hFFFFFFFF,  1'b0, 32'h94967295, 1'b1, 34};
    vecs[6] = '{32'd7,         1'b0, 32'h00000007, 1'b0, 34};
    vecs[7] = '{32'h000000A5,  1'b1, 32'h000000A5, 1'b0, 1};
    vecs[8] = '{32'd10203,     1'b0, 32'h00010203, 1'b0, 34};
    vecs[9] = '{32'd4,         1'b0, 32'h00000004, 1'b0, 34};

    // Reset values, then scan timing from reset release
    #3 rst = 1'b1;
    #2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_bcd", bus.bcd, 32'h0);
    check("rst_ovf", bus.overflow, 1'b0);
    check("rst_an", bus.AN, 8'hFE);
    check("rst_seg", bus.SEGMENT, 8'hC0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("scan_an_k%0d", k), bus.AN, 8'(~(8'b1 << ((k / 4) % 8))));
    end

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].num, vecs[i].hex, b, o, lat, bz);
      check($sformatf("vec%0d_bcd", i), b, vecs[i].exp_bcd);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].exp_ovf);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i), bz, !vecs[i].hex);
      check_display(vecs[i].exp_bcd, vecs[i].exp_ovf, vecs[i].hex, $sformatf("vec%0d", i));
    end

    // Randomized traffic against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      h = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: n = $urandom_range(0, 999);
        1: n = $urandom_range(0, 99999999);
        2: n = $urandom;
        default: n = $urandom_range(99999990, 100000010);
      endcase
      model_conv(n, h, eb, eo);
      run_conv(n, h, b, o, lat, bz);
      tag = $sformatf("rnd%0d_n%0h_h%0d", i, n, h);
      check({tag, "_bcd"}, b, eb);
      check({tag, "_ovf"}, o, eo);
      check({tag, "_lat"}, lat, h ? 1 : 34);
      if (i % 4 == 0) check_display(eb, eo, h, tag);
    end

    // Second start mid-conversion must be ignored
    model_conv(32'd87654321, 1'b0, eb, eo);
    bus.num = 32'd87654321;
    bus.hex_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 9) begin
        bus.num = 32'd11111111;
        bus.hex_mode = 1'b1;
        bus.start = 1'b1;
      end else if (lat == 10) begin
        bus.start = 1'b0;
        bus.hex_mode = 1'b0;
      end
      if (bus.done) break;
    end
    check("restart_lat", lat, 34);
    check("restart_bcd", bus.bcd, eb);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("restart_no_queue", dones, 0);
    check("restart_bcd_hold", bus.bcd, eb);

    // Reset in the middle of a conversion
    bus.num = 32'd55555555;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_bcd", bus.bcd, 32'h0);
    check("midrst_an", bus.AN, 8'hFE);
    check("midrst_seg", bus.SEGMENT, 8'hC0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_bcd_hold", bus.bcd, 32'h0);
    check("midrst_busy_hold", bus.busy, 1'b0);
    run_conv(32'd55555555, 1'b0, b, o, lat, bz);
    check("postrst_bcd", b, 32'h55555555);
    check("postrst_lat", lat, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/number_display.md
Name: number_display

Overview:
- Display-side counterpart of the calculator's number generator: takes the 32-bit value the calculator produces and presents it on the 8-digit multiplexed seven-segment display.
- Converts the value to decimal with an iterative shift-add-3 (double-dabble) engine, or passes it through unchanged in hex mode.
- Applies leading-zero blanking and flags values too large for 8 decimal digits.
- Continuously scans the digit anodes.

Parameters:
- SCAN_DIV, 16'd50000, clk cycles per digit; minimum 2.
- NUM_DIGITS, 8, displayed digits; fixed at 8 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- num  input  32  unsigned value to display.
- start  input  1  single-cycle request to latch num and convert it.
- hex_mode  input  1  1 = show num as 8 hex digits; 0 = show it in decimal.
- busy  output  1  high while a decimal conversion is in progress.
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  32  eight displayed nibbles; digit 7 is bits [31:28].
- overflow  output  1  decimal value exceeds 99999999.
- AN  output  8  digit anodes, active low, one-hot-zero.
- SEGMENT  output  8  {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (async, any time, including mid-conversion): FSM=IDLE, busy=0, done=0, bcd=0, overflow=0, mode register=decimal, scan prescaler=0, digit index=0, AN=8'hFE, SEGMENT=8'hC0 ('0'). Any partial conversion is discarded.
- FSM states: IDLE, CONV, FINISH.
- IDLE, start=1, hex_mode=1: capture num and the mode on that edge. Next edge: bcd<=num, overflow<=0, done=1 for one cycle. Stay in IDLE; busy stays 0. Latency 1.
- IDLE, start=1, hex_mode=0: capture num into a 32-bit shift register, clear the 40-bit BCD accumulator, set the iteration counter to 0, capture the mode, go to CONV, busy=1 from the next cycle.
- CONV, each cycle: for each of the 10 BCD nibbles, add 3 if the nibble is >=5; then shift {accumulator, shift register} left by 1. After 32 iterations go to FINISH.
- FINISH, one cycle:
  - bcd<=accumulator[31:0].
  - overflow<=(accumulator[39:32]!=0).
  - done=1, busy=0, return to IDLE.
  - Latency from the start edge to the done pulse is 34 cycles.
- bcd and overflow change only on the done cycle. The display shows the old value until then.
- start while busy=1 is ignored: no restart, no queueing. num and hex_mode changes while busy have no effect.
- Glyphs:
  - Decimal mode: nibbles 0-9 map to standard glyphs. Nibbles above 9 cannot occur.
  - Hex mode: A-F map to A,b,C,d,E,F.
  - Encodings: '0'=C0, '1'=F9, '2'=A4, '3'=B0, '4'=99, '5'=92, '6'=82, '7'=F8, '8'=80, '9'=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, blank=FF.
- Leading-zero blanking applies in decimal mode only. A digit above the most significant nonzero digit shows FF. Digit 0 is always shown.
- Overflow display: digit 0 shows 'E' (86), all other digits are blank. This persists until the next completed conversion.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. When it wraps, the digit index increments, 7 wraps to 0.
  - AN = ~(1<<index).
  - SEGMENT is registered and updates on the same edge as AN.
  - dp is always 1 (off).
- Scanning runs in every FSM state and is never stalled by a conversion.

Test Plan:
- Decimal conversion: num=32'd12345678, hex_mode=0, start pulse → busy high for the conversion, done pulses exactly 34 cycles after the start edge, bcd=32'h12345678, overflow=0.
- Zero with blanking: num=0, decimal → bcd=0; at index 0 SEGMENT=C0; at indices 1-7 SEGMENT=FF.
- Overflow: num=32'd100000000 → overflow=1, digit 0 shows 86, other digits FF. Then num=32'd99999999 → overflow=0, bcd=32'h99999999.
- Hex pass-through: hex_mode=1, num=32'hDEADBEEF → done 1 cycle after start, busy never high, bcd=DEADBEEF. Digit 7 shows A1 ('d'); digit 0 shows 8E ('F').
- Scan timing with SCAN_DIV=4: AN steps FE,FD,FB,…,7F, changing every 4 cycles, and returns to FE after 32 cycles.
- Robustness:
  - Second start pulse at cycle 10 of a conversion → ignored, and the result equals the first num.
  - rst asserted at cycle 20 of a conversion → asynchronously busy=0, bcd=0, AN=FE, SEGMENT=C0, with no done pulse.
